// File: rtl/jam_pkg.sv
// Shared types and constants for the cost-table evaluation scheduler.
// Arbitration mode is selected in jam_rr_arb by JAM_SCHED_FIXED_PRIO_EN.
package jam_pkg;

    localparam int unsigned IDX_W  = 3;
    localparam int unsigned COST_W = 7;
    localparam int unsigned SUM_W  = 10;
    localparam int unsigned NWORK  = 8;
    localparam int unsigned PERM_W = NWORK * IDX_W;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StDone
    } jam_state_e;

    // Job index assigned to worker w within a packed permutation.
    function automatic logic [IDX_W-1:0] perm_job(input logic [PERM_W-1:0] perm,
                                                  input logic [IDX_W-1:0]  w);
        return perm[IDX_W*int'(w) +: IDX_W];
    endfunction

endpackage

// File: rtl/jam_rr_arb.sv
// Combinational requester arbiter: round-robin from ptr_i upward with wrap, or
// lowest-index-wins when JAM_SCHED_FIXED_PRIO_EN is defined (ptr_i then ignored).
module jam_rr_arb
    import jam_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  gnt_o
);

`ifdef JAM_SCHED_FIXED_PRIO_EN

    logic unused_ptr;
    assign unused_ptr = ^ptr_i;

    // Scan from the top down so the lowest requesting index is the last writer.
    always_comb begin
        gnt_o = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
            end
        end
    end

`else

    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr_i) + k) % int'(NREQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

`endif

endmodule

// File: rtl/jam_cost_sched.sv
// Shared cost-table evaluation scheduler: grants one requester, walks workers 0..7
// through the external table, and returns the summed cost. Option: JAM_SCHED_FIXED_PRIO_EN.
module jam_cost_sched
    import jam_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*PERM_W-1:0] req_perm,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [SUM_W-1:0]       total,
    output logic [IDX_W-1:0]       W,
    output logic [IDX_W-1:0]       J,
    input  logic [COST_W-1:0]      Cost
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    jam_state_e        state_q, state_d;
    logic [NREQ-1:0]   win_q, win_d;
    logic [PERM_W-1:0] perm_q, perm_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]  arb_ptr;
    logic [PERM_W-1:0] perm_sel;

    jam_rr_arb #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i (req),
        .ptr_i (arb_ptr),
        .gnt_o (arb_gnt)
    );

`ifdef JAM_SCHED_FIXED_PRIO_EN

    assign arb_ptr = '0;

`else

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (win_q[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    // Pointer moves past the winner only once its total has been delivered.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StDone) begin
            rr_ptr_d = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign arb_ptr = rr_ptr_q;

`endif

    always_comb begin
        perm_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (arb_gnt[i]) begin
                perm_sel = req_perm[i*PERM_W +: PERM_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        perm_d  = perm_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (|req) begin
                    win_d   = arb_gnt;
                    perm_d  = perm_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StRead;
                end
            end
            StRead: begin
                acc_d = acc_q + SUM_W'(Cost);
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == IDX_W'(NWORK - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            win_q   <= '0;
            perm_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            perm_q  <= perm_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs decode registered state only; nothing flows through from req.
    always_comb begin
        gnt   = (state_q != StIdle) ? win_q : '0;
        done  = (state_q == StDone) ? win_q : '0;
        total = (state_q == StDone) ? acc_q : '0;
        W     = (state_q == StRead) ? cnt_q : '0;
        J     = (state_q == StRead) ? perm_job(perm_q, cnt_q) : '0;
    end

endmodule

// File: tb/tb_jam_cost_sched.sv
// Self-checking bench for jam_cost_sched: transaction-level arbitration and cost-sum
// model with directed and randomized requests against a behavioural cost table.
module tb_jam_cost_sched;

    localparam int N = 4;

    logic          CLK;
    logic          RST;
    logic [N-1:0]  req;
    logic [N*24-1:0] req_perm;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [9:0]    total;
    logic [2:0]    W;
    logic [2:0]    J;
    logic [6:0]    Cost;

    logic [6:0]    tab [64];
    int            checks;
    int            failures;
    int            rr;

    assign Cost = tab[{W, J}];

    jam_cost_sched #(
        .NREQ (N)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .req_perm (req_perm),
        .gnt      (gnt),
        .done     (done),
        .total    (total),
        .W        (W),
        .J        (J),
        .Cost     (Cost)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_total"}, 32'(total), 32'd0);
        chk({tag, "_W"}, 32'(W), 32'd0);
        chk({tag, "_J"}, 32'(J), 32'd0);
    endtask

    // Arbitration rule from the requester's point of view.
    function automatic int pick(input logic [N-1:0] r, input int ptr);
`ifdef JAM_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (r[i]) return i;
`else
        for (int k = 0; k < N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
`endif
        return -1;
    endfunction

    function automatic int perm_cost(input logic [23:0] p);
        int s = 0;
        for (int w = 0; w < 8; w++) s += int'(tab[w*8 + int'(p[w*3 +: 3])]);
        return s;
    endfunction

    task automatic table_mul();
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++) tab[w*8 + j] = 7'(w * j);
    endtask

    task automatic table_rand();
        for (int i = 0; i < 64; i++) tab[i] = 7'($urandom_range(0, 127));
    endtask

    // Called at a falling edge before the grant edge. mod_cycle: drop req and alter the
    // winner's perm in that cycle; abort_cycle: pull reset low in that cycle.
    task automatic burst(input int mod_cycle, input int abort_cycle, output int win);
        logic [23:0]  p;
        logic [N-1:0] oh;
        int           exp_total;
        int           n;
        win = pick(req, rr);
        if (win < 0) begin
            chk("no_request", 32'(req), 32'd1);
            return;
        end
        p         = req_perm[win*24 +: 24];
        exp_total = perm_cost(p);
        oh        = '0;
        oh[win]   = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (gnt === '0 && n < 20);
        chk("grant_latency", 32'(n), 32'd1);
        if (n >= 20) return;
        for (int c = 1; c <= 8; c++) begin
            chk("read_W", 32'(W), 32'(c - 1));
            chk("read_J", 32'(J), 32'(p[(c-1)*3 +: 3]));
            chk("read_gnt", 32'(gnt), 32'(oh));
            chk("read_done", 32'(done), 32'd0);
            if (c == mod_cycle) begin
                req_perm[win*24 +: 24] = 24'($urandom);
                req[win]               = 1'b0;
            end
            if (c == abort_cycle) begin
                RST = 1'b0;
                #1;
                chk_zero_outputs("abort");
                rr = 0;
                return;
            end
            @(negedge CLK);
        end
        chk("done_pulse", 32'(done), 32'(oh));
        chk("done_total", 32'(total), 32'(exp_total));
        chk("done_gnt", 32'(gnt), 32'(oh));
        chk("done_W", 32'(W), 32'd0);
`ifndef JAM_SCHED_FIXED_PRIO_EN
        rr = (win + 1) % N;
`endif
        @(negedge CLK);
        chk("post_gnt", 32'(gnt), 32'd0);
        chk("post_done", 32'(done), 32'd0);
        chk("post_total", 32'(total), 32'd0);
    endtask

    initial begin
        int w;
        checks   = 0;
        failures = 0;
        rr       = 0;
        RST      = 1'b0;
        req      = '0;
        req_perm = '0;
        table_mul();

        #3;
        chk_zero_outputs("reset");
        @(negedge CLK);
        @(negedge CLK);
        chk_zero_outputs("reset_hold");
        RST = 1'b1;

        // Identity perm with Cost=W*J: sum of w*w = 140.
        req_perm[23:0] = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        req            = 4'b0001;
        burst(0, 0, w);
        chk("identity_winner", 32'(w), 32'd0);
        req = '0;
        @(negedge CLK);
        chk_zero_outputs("idle_gap");

        // Reversed perm: sum of w*(7-w) = 56.
        req_perm[23:0] = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        req            = 4'b0001;
        burst(0, 0, w);
        req = '0;

        // Fresh reset, then req0 and req2 together; req0 first, req2 back to back.
        RST = 1'b0;
        #1;
        chk_zero_outputs("reset2");
        rr = 0;
        @(negedge CLK);
        RST = 1'b1;
        table_rand();
        req_perm = {N{24'($urandom)}};
        req_perm[2*24 +: 24] = 24'($urandom);
        req = 4'b0101;
        burst(0, 0, w);
        chk("pair_first", 32'(w), 32'd0);
        req[0] = 1'b0;
        burst(0, 0, w);
        chk("pair_second", 32'(w), 32'd2);

        // Everyone requesting continuously from rr_ptr=3.
        for (int i = 0; i < N; i++) req_perm[i*24 +: 24] = 24'($urandom);
        req = 4'b1111;
        for (int k = 0; k < N; k++) burst(0, 0, w);
        req = '0;

        // Perm changed and req dropped mid-burst: latched copy must be used.
        req_perm[23:0] = 24'($urandom);
        req            = 4'b0001;
        burst(3, 0, w);
        chk("mod_req_dropped", 32'(req), 32'd0);

        // Reset in cycle 5 of req0's burst, then req1 alone after release.
        req_perm[23:0]  = 24'($urandom);
        req_perm[47:24] = 24'($urandom);
        req             = 4'b0001;
        burst(0, 5, w);
        req = 4'b0010;
        @(negedge CLK);
        chk_zero_outputs("abort_hold");
        RST = 1'b1;
        burst(0, 0, w);
        chk("after_abort_winner", 32'(w), 32'd1);
        req = '0;

        // Randomized traffic, keeping held requests held until served.
        table_rand();
        for (int i = 0; i < N; i++) req_perm[i*24 +: 24] = 24'($urandom);
        req = 4'($urandom_range(1, 15));
        repeat (16) begin
            burst(0, 0, w);
            if ($urandom_range(0, 1) == 1) req[w] = 1'b0;
            for (int i = 0; i < N; i++) if (!req[i]) req_perm[i*24 +: 24] = 24'($urandom);
            req = req | 4'($urandom_range(0, 15));
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 3) == 0) table_rand();
        end
        req = '0;
        @(negedge CLK);
        @(negedge CLK);
        chk_zero_outputs("final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jam_cost_sched.md
# jam_cost_sched

Shared cost-table evaluation scheduler for the job-assignment datapath. Up to NREQ permutation engines each submit a complete worker→job assignment. The block arbitrates the single external cost table (W/J address, Cost data), walks workers 0..7 for the winner, accumulates the 10-bit total cost, and returns it to that requester with a one-cycle done pulse. It sits between the permutation generators and the cost-table port, replacing per-engine direct table access.

## Interface
- NREQ, 4, number of requesters (2..8)
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  reset; asynchronous, active-low
- req  in  NREQ  request per requester; level, held until its done
- req_perm  in  NREQ*24  per requester: eight 3-bit job indices, worker w at bits [3w+2:3w]
- gnt  out  NREQ  one-hot; high for the granted requester from grant through its done cycle
- done  out  NREQ  one-cycle pulse to the requester whose total is valid
- total  out  10  summed cost; valid only while any done bit is high, else 0
- W  out  3  cost-table worker address
- J  out  3  cost-table job address
- Cost  in  7  cost-table data, combinational in W/J, sampled same cycle

## Operation
- States: IDLE, READ, DONE.
- IDLE: W=J=0, gnt=0. If any req bit is high, select a winner with the round-robin arbiter, starting at pointer rr_ptr and searching upward with wrap. Latch the winner's req_perm into an internal 24-bit register. Set gnt, clear acc, clear cnt, and go to READ.
- READ: W=cnt and J=perm_q[cnt] (from the latched copy; later changes to req_perm are ignored).
  - Each cycle: acc <= acc + Cost (zero-extended to 10 bits), then cnt++.
  - After cnt=7 is accumulated, go to DONE.
- DONE: done[winner]=1 and total=acc for exactly one cycle. Then gnt=0, rr_ptr <= winner+1 (mod NREQ), and go to IDLE.
- Arithmetic: max sum 8×127=1016, so no overflow in 10 bits. acc never wraps.
- A req dropped during READ does not abort the burst: it still completes and done is still pulsed.
- A requester holding req after its done competes again from the next IDLE. It is served again only if no requester above it in round-robin order is requesting.
- Invalid perms (duplicate job indices) are not checked; the costs are summed as addressed.
- Reset low at any time: all outputs 0, state IDLE, rr_ptr=0, acc=0, cnt=0, perm_q=0. This takes effect immediately and asynchronously. An in-flight burst is discarded with no done pulse.

## Timing
- Request seen high at edge 0 → gnt high after edge 0. W=0..7 in cycles 1..8. done/total in cycle 9. gnt low and IDLE in cycle 10.
- Earliest next grant is at edge 10, giving a throughput of one evaluation per 10 cycles.
- W, J, gnt, done and total are registered-state decodes with no combinational path from req.
- Cost is sampled at the same edge that advances W/J; the table must settle within one cycle.
- Reset values: gnt=0, done=0, total=0, W=0, J=0.

## Configuration
- JAM_SCHED_FIXED_PRIO_EN:
  - Defined: the arbiter uses fixed priority, where the lowest index wins; rr_ptr is not implemented and starvation is allowed.
  - Undefined (default): round-robin as described in Operation.

## Structure
- jam_pkg holds:
  - the state enum (IDLE/READ/DONE)
  - IDX_W=3, COST_W=7, SUM_W=10, NWORK=8
  - the PERM_W=24 constant
- One sub-module, jam_rr_arb: inputs req[NREQ] and ptr; output one-hot grant. It is purely combinational and contains both the round-robin and fixed-priority variants under the macro.
- The top level holds the FSM, counter, accumulator and perm latch.

## Test plan
- Single requester, table model Cost=W*J:
  - req[0] with identity perm → done[0] at cycle 9, total=140.
  - Reversed perm 7..0 → total=56.
- req[0] and req[2] rise together after reset → req0 done at cycle 9, total=140; req2 granted at edge 10 and done at cycle 19.
- All four requesting continuously after req2 served (rr_ptr=3) → service order 3,0,1,2. Each gnt is one-hot with no gaps beyond the DONE cycle.
- req_perm[0] changed and req[0] dropped at cycle 3 of a burst → W/J follow the latched perm, done[0] still pulses, total unchanged from the original perm.
- RST asserted low at cycle 5 of a burst → W, J, gnt, done and total are 0 immediately. After release with req[1] high → req1 is granted, total is correct, and no done pulse appears for the aborted requester.
- With JAM_SCHED_FIXED_PRIO_EN, req[0] and req[1] held continuously → only requester 0 is ever granted.
